// File: rtl/conv_bcd_pkg.sv
// ============================================================================
// Module : conv_bcd_pkg
// Brief  : Shared types and constants for the binary-to-BCD converter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_bcd_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        FIN       = 2'd2
    } estado_t;

    localparam logic [15:0] BCD_MAX      = 16'h9999;
    localparam logic [31:0] VALOR_MAX    = 32'd9999;
    localparam int          ANCHO_DIGITO = 4;
    localparam int          NUM_DIGITOS  = 4;

endpackage

`default_nettype wire

// File: rtl/ajuste_digito_bcd.sv
// ============================================================================
// Module : ajuste_digito_bcd
// Brief  : Add-3 correction of one BCD nibble ahead of the shift.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ajuste_digito_bcd
    import conv_bcd_pkg::*;
(
    input  logic [ANCHO_DIGITO-1:0] digito_i,
    output logic [ANCHO_DIGITO-1:0] digito_o
);

    always_comb begin
        digito_o = digito_i;
        if (digito_i >= 4'd5) begin
            digito_o = digito_i + 4'd3;
        end
    end

endmodule

`default_nettype wire

// File: rtl/convertidor_binario_bcd.sv
// ============================================================================
// Module : convertidor_binario_bcd
// Brief  : Iterative shift-and-add-3 binary to 4-digit BCD converter with
//          start/busy/done handshake. Define CONVERTIDOR_BCD_APAGAR_CEROS_EN
//          to add the leading-zero blank mask output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module convertidor_binario_bcd
    import conv_bcd_pkg::*;
#(
    parameter int ANCHO_ENTRADA = 14
)(
    input  logic                     i_Reloj,
    input  logic                     i_Reset,
    input  logic                     i_Inicio,
    input  logic [ANCHO_ENTRADA-1:0] i_Binario,
    output logic                     o_Ocupado,
    output logic                     o_Listo,
    output logic                     o_Desborde,
    output logic [3:0]               o_Datos_0,
    output logic [3:0]               o_Datos_1,
    output logic [3:0]               o_Datos_2,
    output logic [3:0]               o_Datos_3
`ifdef CONVERTIDOR_BCD_APAGAR_CEROS_EN
    ,
    output logic [3:0]               o_Apagar_4_Bits
`endif
);

    localparam int                    ANCHO_CONT = $clog2(ANCHO_ENTRADA + 1);
    localparam logic [ANCHO_CONT-1:0] CONT_CARGA = ANCHO_CONT'(ANCHO_ENTRADA);
    localparam logic [ANCHO_CONT-1:0] CONT_UNO   = ANCHO_CONT'(1);

    estado_t                  estado_q;
    logic [ANCHO_ENTRADA-1:0] bin_q;
    logic [15:0]              bcd_q;
    logic [ANCHO_CONT-1:0]    cont_q;
    logic                     desborde_pend_q;
    logic                     ocupado_q;
    logic                     listo_q;
    logic                     desborde_q;
    logic [15:0]              datos_q;

    logic [15:0]              bcd_ajustado_d;
    logic [15:0]              resultado_d;
    logic                     desborde_d;

    generate
        for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
            ajuste_digito_bcd u_ajuste (
                .digito_i (bcd_q[g*ANCHO_DIGITO +: ANCHO_DIGITO]),
                .digito_o (bcd_ajustado_d[g*ANCHO_DIGITO +: ANCHO_DIGITO])
            );
        end
    endgenerate

    // Overflow is decided on the captured binary, since the 16-bit accumulator cannot hold 5 digits.
    assign desborde_d  = {{(32-ANCHO_ENTRADA){1'b0}}, i_Binario} > VALOR_MAX;
    assign resultado_d = desborde_pend_q ? BCD_MAX : bcd_q;

`ifdef CONVERTIDOR_BCD_APAGAR_CEROS_EN
    logic [3:0] mascara_q;
    logic [3:0] mascara_d;

    always_comb begin
        mascara_d    = 4'b0000;
        mascara_d[3] = (resultado_d[15:12] == 4'd0);
        mascara_d[2] = mascara_d[3] && (resultado_d[11:8] == 4'd0);
        mascara_d[1] = mascara_d[2] && (resultado_d[7:4] == 4'd0);
    end

    assign o_Apagar_4_Bits = mascara_q;
`endif

    always_ff @(posedge i_Reloj) begin
        if (i_Reset) begin
            estado_q        <= REPOSO;
            bin_q           <= '0;
            bcd_q           <= '0;
            cont_q          <= '0;
            desborde_pend_q <= 1'b0;
            ocupado_q       <= 1'b0;
            listo_q         <= 1'b0;
            desborde_q      <= 1'b0;
            datos_q         <= '0;
`ifdef CONVERTIDOR_BCD_APAGAR_CEROS_EN
            mascara_q       <= 4'b1110;
`endif
        end else begin
            listo_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (i_Inicio) begin
                        bin_q           <= i_Binario;
                        bcd_q           <= '0;
                        cont_q          <= CONT_CARGA;
                        desborde_pend_q <= desborde_d;
                        ocupado_q       <= 1'b1;
                        estado_q        <= CONVIERTE;
                    end
                end
                CONVIERTE: begin
                    {bcd_q, bin_q} <= {bcd_ajustado_d, bin_q} << 1;
                    cont_q         <= cont_q - CONT_UNO;
                    if (cont_q == CONT_UNO) begin
                        estado_q <= FIN;
                    end
                end
                FIN: begin
                    datos_q    <= resultado_d;
                    desborde_q <= desborde_pend_q;
                    listo_q    <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estado_q   <= REPOSO;
`ifdef CONVERTIDOR_BCD_APAGAR_CEROS_EN
                    mascara_q  <= mascara_d;
`endif
                end
                default: begin
                    estado_q <= REPOSO;
                end
            endcase
        end
    end

    assign o_Ocupado  = ocupado_q;
    assign o_Listo    = listo_q;
    assign o_Desborde = desborde_q;
    assign o_Datos_0  = datos_q[3:0];
    assign o_Datos_1  = datos_q[7:4];
    assign o_Datos_2  = datos_q[11:8];
    assign o_Datos_3  = datos_q[15:12];

endmodule

`default_nettype wire
